efuse_ctrl: RTL

EFUSE_CTRL -- requirements
Module: efuse_ctrl

---
 rtl/efuse_ctrl.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/efuse_ctrl.sv
// eFuse macro sequencer: timed single-word read and bit-serial program of a 128x8 fuse array.
// Optional post-program read-back with error flag: define EFUSE_CTRL_PGM_VERIFY_EN.
`timescale 1ns/1ps
module efuse_ctrl #(
  parameter int T_SU = 2,
  parameter int T_RD = 4,
  parameter int T_PG = 40,
  parameter int T_HD = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       wr,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       err,
  output logic       efuse_csb,
  output logic       efuse_strobe,
  output logic       efuse_load,
  output logic       efuse_pgenb,
  output logic       efuse_vddq,
  output logic [9:0] efuse_a,
  input  logic [7:0] efuse_q
);

  localparam int T_M1  = (T_SU > T_RD) ? T_SU : T_RD;
  localparam int T_M2  = (T_PG > T_HD) ? T_PG : T_HD;
  localparam int T_MAX = (T_M1 > T_M2) ? T_M1 : T_M2;
  localparam int CNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  typedef enum logic [3:0] {
    IDLE, RD_SU, RD_STB, RD_HD, PG_SU, PG_STB, PG_HD, PG_NEXT, GAP, DONE
  } state_t;

`ifdef EFUSE_CTRL_PGM_VERIFY_EN
  localparam state_t PROG_EXIT = GAP;
`else
  localparam state_t PROG_EXIT = DONE;
`endif

  // The counter holds the remaining cycles minus one of the current timed state.
  function automatic logic [CNT_W-1:0] dur(input int t);
    return CNT_W'(t - 1);
  endfunction

  function automatic logic [2:0] lsb_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [6:0]       r_addr, w_addr_nxt;
  logic [7:0]       r_pend, w_pend_nxt, w_pend_clr;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [7:0]       r_rdata, w_rdata_nxt;
  logic             w_cnt_last;
  logic             r_busy, r_done, w_busy_nxt, w_done_nxt;
  logic             r_csb, r_strobe, r_load, r_pgenb, r_vddq;
  logic             w_csb, w_strobe, w_load, w_pgenb, w_vddq;
  logic [9:0]       r_a, w_a;
`ifdef EFUSE_CTRL_PGM_VERIFY_EN
  logic [7:0]       r_wdata, w_wdata_nxt;
  logic             r_vfy, w_vfy_nxt;
  logic             r_err, w_err_nxt;
`endif

  assign w_cnt_last = (r_cnt == '0);
  assign w_pend_clr = r_pend & ~(8'd1 << r_idx);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_last ? r_cnt : r_cnt - CNT_W'(1);
    w_addr_nxt  = r_addr;
    w_pend_nxt  = r_pend;
    w_idx_nxt   = r_idx;
    w_rdata_nxt = r_rdata;
`ifdef EFUSE_CTRL_PGM_VERIFY_EN
    w_wdata_nxt = r_wdata;
    w_vfy_nxt   = r_vfy;
    w_err_nxt   = r_err;
`endif
    case (r_state)
      IDLE: begin
        if (req) begin
          w_addr_nxt = addr;
          w_pend_nxt = wdata;
          w_idx_nxt  = lsb_idx(wdata);
          w_cnt_nxt  = dur(T_SU);
`ifdef EFUSE_CTRL_PGM_VERIFY_EN
          w_wdata_nxt = wdata;
          w_vfy_nxt   = wr;
`endif
          if (!wr)               w_state_nxt = RD_SU;
          else if (wdata == 8'h00) w_state_nxt = PROG_EXIT;
          else                   w_state_nxt = PG_SU;
        end
      end
      RD_SU: if (w_cnt_last) begin
        w_state_nxt = RD_STB;
        w_cnt_nxt   = dur(T_RD);
      end
      RD_STB: if (w_cnt_last) begin
        w_state_nxt = RD_HD;
        w_cnt_nxt   = dur(T_HD);
      end
      RD_HD: if (w_cnt_last) begin
        w_state_nxt = DONE;
        w_rdata_nxt = efuse_q;
`ifdef EFUSE_CTRL_PGM_VERIFY_EN
        if (r_vfy) w_err_nxt = ((efuse_q & r_wdata) != r_wdata);
`endif
      end
      PG_SU: if (w_cnt_last) begin
        w_state_nxt = PG_STB;
        w_cnt_nxt   = dur(T_PG);
      end
      PG_STB: if (w_cnt_last) begin
        w_state_nxt = PG_HD;
        w_cnt_nxt   = dur(T_HD);
      end
      PG_HD: if (w_cnt_last) begin
        w_state_nxt = PG_NEXT;
      end
      PG_NEXT: begin
        w_pend_nxt = w_pend_clr;
        w_cnt_nxt  = dur(T_SU);
        if (w_pend_clr != 8'h00) begin
          w_idx_nxt   = lsb_idx(w_pend_clr);
          w_state_nxt = PG_SU;
        end else begin
          w_state_nxt = PROG_EXIT;
        end
      end
      GAP: begin
`ifdef EFUSE_CTRL_PGM_VERIFY_EN
        if (w_cnt_last) begin
          w_state_nxt = RD_SU;
          w_cnt_nxt   = dur(T_SU);
        end
`else
        w_state_nxt = IDLE;
`endif
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Macro pins are registered from the next state so they leave the flops glitch-free.
  always_comb begin
    w_busy_nxt = (w_state_nxt != IDLE);
    w_done_nxt = (w_state_nxt == DONE);
    w_csb      = 1'b1;
    w_strobe   = 1'b0;
    w_load     = 1'b0;
    w_pgenb    = 1'b1;
    w_vddq     = 1'b0;
    w_a        = 10'h000;
    case (w_state_nxt)
      RD_SU, RD_STB, RD_HD: begin
        w_csb    = 1'b0;
        w_load   = 1'b1;
        w_strobe = (w_state_nxt == RD_STB);
        w_a      = {3'b000, w_addr_nxt};
      end
      PG_SU, PG_STB, PG_HD, PG_NEXT: begin
        w_csb    = 1'b0;
        w_pgenb  = 1'b0;
        w_vddq   = 1'b1;
        w_strobe = (w_state_nxt == PG_STB);
        w_a      = {w_idx_nxt, w_addr_nxt};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr   <= 7'h00;
      r_pend   <= 8'h00;
      r_idx    <= 3'd0;
      r_rdata  <= 8'h00;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_csb    <= 1'b1;
      r_strobe <= 1'b0;
      r_load   <= 1'b0;
      r_pgenb  <= 1'b1;
      r_vddq   <= 1'b0;
      r_a      <= 10'h000;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_addr   <= w_addr_nxt;
      r_pend   <= w_pend_nxt;
      r_idx    <= w_idx_nxt;
      r_rdata  <= w_rdata_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_csb    <= w_csb;
      r_strobe <= w_strobe;
      r_load   <= w_load;
      r_pgenb  <= w_pgenb;
      r_vddq   <= w_vddq;
      r_a      <= w_a;
    end
  end

`ifdef EFUSE_CTRL_PGM_VERIFY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdata <= 8'h00;
      r_vfy   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_wdata <= w_wdata_nxt;
      r_vfy   <= w_vfy_nxt;
      r_err   <= w_err_nxt;
    end
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign busy         = r_busy;
  assign done         = r_done;
  assign rdata        = r_rdata;
  assign efuse_csb    = r_csb;
  assign efuse_strobe = r_strobe;
  assign efuse_load   = r_load;
  assign efuse_pgenb  = r_pgenb;
  assign efuse_vddq   = r_vddq;
  assign efuse_a      = r_a;

endmodule
